// File: rtl/wb_mul_responder.sv
// Wishbone classic responder wrapped around a shift-add WIDTH x WIDTH multiplier.
// Register window (word select = adr[3:2]):
//   0x0 CTRL   W: bit0 start, bit2 irq_en   R: bit0 busy, bit1 done, bit2 irq_en
//   0x4 OPA    operand A
//   0x8 OPB    operand B
//   0xC RESULT product (read only)
//
// state  | meaning
// S_IDLE | no multiply in progress, start accepted
// S_RUN  | one shift-add iteration per cycle, WIDTH cycles total
module wb_mul_responder #(
  parameter int          WIDTH     = 5,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFF0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o,
  output logic        busy_o
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_q, state_d;
  logic            hit, req, wr_en;
  logic            wr_ctrl, wr_opa, wr_opb;
  logic            start_go, last_iter;
  logic [WIDTH-1:0] opa_q, opb_q, mplier_q;
  logic [PW-1:0]   mcand_q, acc_q, acc_sum, result_q;
  logic [CW-1:0]   count_q;
  logic            done_q, irq_en_q;
  logic [31:0]     rd_data;

  assign hit      = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
  // Blocking req while ack is high forces a one-cycle gap between back-to-back accesses.
  assign req      = wbs_stb_i & wbs_cyc_i & hit & ~wbs_ack_o;
  assign wr_en    = req & wbs_we_i & wbs_sel_i[0];
  assign wr_ctrl  = wr_en & (wbs_adr_i[3:2] == 2'd0);
  assign wr_opa   = wr_en & (wbs_adr_i[3:2] == 2'd1);
  assign wr_opb   = wr_en & (wbs_adr_i[3:2] == 2'd2);

  assign busy_o    = (state_q == S_RUN);
  assign start_go  = wr_ctrl & wbs_dat_i[0] & ~busy_o;
  assign last_iter = busy_o & (count_q == CW'(WIDTH - 1));
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign irq_o = done_q & irq_en_q;

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state: run for WIDTH iterations after an accepted start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_go) state_d = S_RUN;
      S_RUN:   if (last_iter) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read mux; RESULT forwards the final sum so a read on the completion edge sees it.
  always_comb begin
    rd_data = '0;
    case (wbs_adr_i[3:2])
      2'd0: rd_data[2:0]       = {irq_en_q, done_q, busy_o};
      2'd1: rd_data[WIDTH-1:0] = opa_q;
      2'd2: rd_data[WIDTH-1:0] = opb_q;
      2'd3: rd_data[PW-1:0]    = last_iter ? acc_sum : result_q;
      default: rd_data = '0;
    endcase
  end

  // Bus response: single-cycle registered ack, read data only alongside a read ack.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req & ~wbs_we_i) ? rd_data : '0;
    end
  end

  // Software-visible registers: operands, irq enable, sticky done, result.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      opa_q    <= '0;
      opb_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      if (wr_opa)  opa_q    <= wbs_dat_i[WIDTH-1:0];
      if (wr_opb)  opb_q    <= wbs_dat_i[WIDTH-1:0];
      if (wr_ctrl) irq_en_q <= wbs_dat_i[2];
      if (start_go)       done_q <= 1'b0;
      else if (last_iter) done_q <= 1'b1;
      if (last_iter) result_q <= acc_sum;
    end
  end

  // Shift-add datapath: operands are snapshotted at start so later writes cannot disturb a run.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (start_go) begin
      mcand_q  <= {{WIDTH{1'b0}}, opa_q};
      mplier_q <= opb_q;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (busy_o) begin
      acc_q    <= acc_sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_wb_mul_responder.sv
// Scoreboard bench for wb_mul_responder: bus tasks push expected read data
// computed from a time-based behavioural model; a negedge monitor pops and
// compares on every ack and also tracks busy_o / irq_o each cycle.
module tb_wb_mul_responder;
  localparam int W = 5;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        stb = 1'b0, cyc_i = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] dat = '0, adr = '0;
  logic        ack, irq, busy;
  logic [31:0] dat_o;

  wb_mul_responder dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_ni(wb_rst_ni),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc_i),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_dat_i(dat),
    .wbs_adr_i(adr),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_o),
    .irq_o    (irq),
    .busy_o   (busy)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // Reference model: state is derived from the edge number of the last accepted start.
  int          m_start = -1;
  logic [31:0] m_opa = 0, m_opb = 0, m_prod = 0, m_res_old = 0;
  bit          m_irq_en = 0;

  function automatic bit busy_at(int k);
    return (m_start >= 0) && (k > m_start) && (k <= m_start + W);
  endfunction

  function automatic bit done_at(int k);
    return (m_start >= 0) && (k > m_start + W);
  endfunction

  function automatic logic [31:0] result_at(int k);
    if (m_start >= 0 && k >= m_start + W) return m_prod;
    return m_res_old;
  endfunction

  function automatic logic [31:0] read_model(logic [1:0] r, int k);
    case (r)
      2'd0: return {29'd0, m_irq_en, done_at(k), busy_at(k)};
      2'd1: return m_opa;
      2'd2: return m_opb;
      default: return result_at(k);
    endcase
  endfunction

  function automatic void apply_write(logic [1:0] r, logic [31:0] d, int k);
    case (r)
      2'd0: begin
        if (d[0] && !busy_at(k)) begin
          m_res_old = result_at(k);
          m_prod    = m_opa * m_opb;
          m_start   = k;
        end
        m_irq_en = d[2];
      end
      2'd1: m_opa = d % (1 << W);
      2'd2: m_opb = d % (1 << W);
      default: ;
    endcase
  endfunction

  function automatic void model_reset();
    m_start = -1; m_opa = 0; m_opb = 0; m_prod = 0; m_res_old = 0; m_irq_en = 0;
  endfunction

  typedef struct {
    bit          is_read;
    logic [31:0] exp;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: status outputs every cycle, scoreboard pop on every ack.
  always @(negedge wb_clk_i) begin
    exp_t e;
    check("busy_o", 32'(busy), 32'(busy_at(cyc + 1)));
    check("irq_o", 32'(irq), 32'(done_at(cyc + 1) & m_irq_en));
    if (ack) begin
      if (sb_q.size() == 0) check("unexpected_ack", 32'(ack), 32'd0);
      else begin
        e = sb_q.pop_front();
        if (e.is_read) check(e.name, dat_o, e.exp);
      end
    end else begin
      check("dat_idle", dat_o, 32'd0);
    end
  end

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input string name);
    int   k;
    exp_t e;
    bit   h;
    h = ((a & 32'hFFFF_FFF0) == 32'h3000_0000);
    stb = 1'b1; cyc_i = 1'b1; we = w; adr = a; dat = d; sel = s;
    @(posedge wb_clk_i); #1;
    k = cyc;
    stb = 1'b0; cyc_i = 1'b0; we = 1'b0;
    check({name, "_ack"}, 32'(ack), 32'(h));
    if (h) begin
      e.is_read = !w;
      e.name    = name;
      e.exp     = w ? 32'd0 : read_model(a[3:2], k);
      sb_q.push_back(e);
      if (w && s[0]) apply_write(a[3:2], d, k);
    end
    @(posedge wb_clk_i); #1;
  endtask

  localparam logic [31:0] A_CTRL = 32'h3000_0000;
  localparam logic [31:0] A_OPA  = 32'h3000_0004;
  localparam logic [31:0] A_OPB  = 32'h3000_0008;
  localparam logic [31:0] A_RES  = 32'h3000_000C;

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string name);
    xfer(1'b1, a, d, 4'hF, name);
  endtask

  task automatic rd(input logic [31:0] a, input string name);
    xfer(1'b0, a, 32'd0, 4'h0, name);
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ctrl, input string name);
    wr(A_OPA, a, "wr_opa");
    wr(A_OPB, b, "wr_opb");
    wr(A_CTRL, ctrl, "wr_ctrl");
    rd(A_CTRL, {name, "_poll"});
    wait_cycles(W);
    rd(A_CTRL, {name, "_ctrl"});
    rd(A_RES, {name, "_res"});
  endtask

  bit pat[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    exp_t e;
    logic [31:0] a, d;
    logic [3:0]  s;
    int          op;

    model_reset();
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_ni = 1'b1;
    wait_cycles(1);

    rd(A_CTRL, "rst_ctrl");
    rd(A_OPA, "rst_opa");
    rd(A_RES, "rst_res");

    run_mul(32'd31, 32'd31, 32'h5, "mul_31x31");
    run_mul(32'd21, 32'd10, 32'h1, "mul_21x10");
    run_mul(32'd0, 32'd17, 32'h1, "mul_0x17");

    // Restart while busy is ignored; operand rewrite mid-run does not disturb the result.
    wr(A_OPA, 32'd31, "wr_opa");
    wr(A_OPB, 32'd31, "wr_opb");
    wr(A_CTRL, 32'h1, "start");
    wr(A_CTRL, 32'h1, "restart_busy");
    wr(A_OPA, 32'd3, "wr_opa_mid");
    wait_cycles(3);
    rd(A_RES, "res_after_restart");
    rd(A_OPA, "opa_after_mid");
    wr(A_CTRL, 32'h1, "start_3x31");
    wait_cycles(W);
    rd(A_RES, "res_3x31");

    // Held strobe: ack 0,1,0,1.
    stb = 1'b1; cyc_i = 1'b1; we = 1'b0; adr = A_OPA; sel = 4'h0;
    for (int i = 0; i < 2; i++) begin
      e.is_read = 1'b1; e.exp = m_opa; e.name = "held_rd";
      sb_q.push_back(e);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge wb_clk_i);
      check("held_ack", 32'(ack), 32'(pat[i]));
    end
    stb = 1'b0; cyc_i = 1'b0;
    wait_cycles(1);

    xfer(1'b0, 32'h3000_0010, 32'd0, 4'hF, "miss");
    xfer(1'b1, A_OPA, 32'd7, 4'b0010, "opa_sel_nolane");
    rd(A_OPA, "opa_after_nolane");
    wr(A_RES, 32'h155, "wr_result");
    rd(A_RES, "res_after_wr");

    // IRQ gating.
    run_mul(32'd6, 32'd7, 32'h1, "irq_off");
    wr(A_CTRL, 32'h4, "irq_en_on");
    wait_cycles(2);
    wr(A_CTRL, 32'h5, "start_clears_done");
    wait_cycles(W);
    wr(A_CTRL, 32'h0, "irq_en_off");
    rd(A_CTRL, "ctrl_irq_off");

    // Reset mid-multiply.
    wr(A_OPA, 32'd13, "wr_opa");
    wr(A_OPB, 32'd11, "wr_opb");
    wr(A_CTRL, 32'h5, "start_pre_rst");
    wb_rst_ni = 1'b0;
    model_reset();
    sb_q.delete();
    wait_cycles(2);
    wb_rst_ni = 1'b1;
    wait_cycles(1);
    rd(A_RES, "res_after_rst");
    rd(A_CTRL, "ctrl_after_rst");

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      s  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      d  = $urandom;
      a  = {28'h3000_000, 2'($urandom_range(0, 3)), 2'($urandom)};
      case (op)
        0, 1: xfer(1'b1, {a[31:4], 2'd1, a[1:0]}, d, s, "rnd_opa");
        2, 3: xfer(1'b1, {a[31:4], 2'd2, a[1:0]}, d, s, "rnd_opb");
        4:    xfer(1'b1, {a[31:4], 2'd0, a[1:0]}, d, s, "rnd_ctrl");
        5, 6, 7: xfer(1'b0, a, d, s, "rnd_rd");
        8:    xfer($urandom_range(0, 1) == 1, 32'h3000_0000 + 32'(16 * $urandom_range(1, 4)), d, s, "rnd_miss");
        default: wait_cycles($urandom_range(0, 6));
      endcase
    end

    wait_cycles(W + 2);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
